// File: rtl/wheel_speed_scheduler.sv
// Wheel-speed window scheduler: per-wheel synchronised edge counters share one window
// timer; each window's snapshot is streamed out one wheel per valid/ready beat.

module wheel_speed_lane #(
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             enc_a,
   input  logic             count_en,
   input  logic             win_end,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             prev_q, prev_d;
   logic             rise;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign rise = sync2_q & ~prev_q;
   assign cnt  = cnt_q;
   assign sat  = (cnt_q == CNT_MAX);

   always_comb begin
      sync1_d = enc_a;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      cnt_d   = cnt_q;
      // an edge on the window-end cycle opens the new window rather than the old one
      if (!count_en)
         cnt_d = '0;
      else if (win_end)
         cnt_d = rise ? CNT_W'(1) : '0;
      else if (rise && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

module wheel_speed_scheduler #(
   parameter int N_WHEELS    = 4,
   parameter int WINDOW_CLKS = 200000,
   parameter int CNT_W       = 8,
   parameter int ID_W        = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                enable,
   input  logic [N_WHEELS-1:0] enc_a,
   output logic                window_strb,
   output logic                spd_valid,
   input  logic                spd_ready,
   output logic [ID_W-1:0]     spd_id,
   output logic [CNT_W-1:0]    spd_data,
   output logic                spd_sat,
   output logic                overrun
);
   localparam int               TMR_W   = $clog2(WINDOW_CLKS);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(WINDOW_CLKS - 1);
   localparam logic [ID_W-1:0]  ID_LAST = ID_W'(N_WHEELS - 1);

   typedef enum logic {W_IDLE, W_COUNT} win_state_e;
   typedef enum logic {S_IDLE, S_SEND}  snd_state_e;

   win_state_e                        win_state_q, win_state_d;
   snd_state_e                        snd_state_q, snd_state_d;
   logic [TMR_W-1:0]                  timer_q, timer_d;
   logic                              strb_q, strb_d;
   logic [N_WHEELS-1:0][CNT_W-1:0]    snap_q, snap_d;
   logic [N_WHEELS-1:0]               snap_sat_q, snap_sat_d;
   logic [ID_W-1:0]                   idx_q, idx_d;
   logic                              valid_q, valid_d;
   logic                              overrun_q, overrun_d;

   logic [N_WHEELS-1:0][CNT_W-1:0]    cnt;
   logic [N_WHEELS-1:0]               cnt_sat;
   logic                              count_en;
   logic                              end_evt;

   assign count_en = (win_state_q == W_COUNT) && enable;
   // strb_q is high exactly on the cycle the timer sits at its last count
   assign end_evt  = strb_q;

   for (genvar i = 0; i < N_WHEELS; i++) begin : g_lane
      wheel_speed_lane #(.CNT_W(CNT_W)) u_lane (
         .CLK      (CLK),
         .RST      (RST),
         .enc_a    (enc_a[i]),
         .count_en (count_en),
         .win_end  (end_evt),
         .cnt      (cnt[i]),
         .sat      (cnt_sat[i])
      );
   end

   always_comb begin
      win_state_d = win_state_q;
      timer_d     = timer_q;
      case (win_state_q)
         W_IDLE: begin
            timer_d = '0;
            if (enable) win_state_d = W_COUNT;
         end
         default: begin
            timer_d = (timer_q == TMR_MAX) ? '0 : timer_q + TMR_W'(1);
            if (!enable) begin
               win_state_d = W_IDLE;
               timer_d     = '0;
            end
         end
      endcase
      strb_d = (win_state_d == W_COUNT) && (timer_d == TMR_MAX);
   end

   always_comb begin
      snd_state_d = snd_state_q;
      snap_d      = snap_q;
      snap_sat_d  = snap_sat_q;
      idx_d       = idx_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      case (snd_state_q)
         S_IDLE: begin
            if (end_evt) begin
               snap_d      = cnt;
               snap_sat_d  = cnt_sat;
               idx_d       = '0;
               valid_d     = 1'b1;
               snd_state_d = S_SEND;
            end
         end
         default: begin
            // a snapshot arriving mid-stream is dropped; the one in flight finishes intact
            if (end_evt) overrun_d = 1'b1;
            if (spd_ready) begin
               if (idx_q == ID_LAST) begin
                  idx_d       = '0;
                  valid_d     = 1'b0;
                  snd_state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + ID_W'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         win_state_q <= W_IDLE;
         snd_state_q <= S_IDLE;
         timer_q     <= '0;
         strb_q      <= 1'b0;
         snap_q      <= '0;
         snap_sat_q  <= '0;
         idx_q       <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         win_state_q <= win_state_d;
         snd_state_q <= snd_state_d;
         timer_q     <= timer_d;
         strb_q      <= strb_d;
         snap_q      <= snap_d;
         snap_sat_q  <= snap_sat_d;
         idx_q       <= idx_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign window_strb = strb_q;
   assign spd_valid   = valid_q;
   assign spd_id      = idx_q;
   assign spd_data    = snap_q[idx_q];
   assign spd_sat     = snap_sat_q[idx_q];
   assign overrun     = overrun_q;
endmodule

// File: tb/tb_wheel_speed_scheduler.sv
// Scoreboard bench for wheel_speed_scheduler: expected beats queued at stimulus time,
// popped and compared on each handshake; a second instance with 4-bit counters covers saturation.

module tb_wheel_speed_scheduler;
   localparam int WIN = 100;

   logic       clk = 1'b0;
   logic       rst, enable, en4, spd_ready;
   logic [3:0] enc_a;
   logic       window_strb, spd_valid, spd_sat, overrun;
   logic [1:0] spd_id;
   logic [7:0] spd_data;
   logic       strb4, valid4, sat4, ovr4;
   logic [1:0] id4;
   logic [3:0] data4;

   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   logic [15:0] q[$];
   logic [15:0] q4[$];
   int         beat_cyc[$];
   logic       stall;
   logic [15:0] stall_v;

   wheel_speed_scheduler #(.N_WHEELS(4), .WINDOW_CLKS(WIN), .CNT_W(8), .ID_W(2)) dut (
      .CLK(clk), .RST(rst), .enable(enable), .enc_a(enc_a), .window_strb(window_strb),
      .spd_valid(spd_valid), .spd_ready(spd_ready), .spd_id(spd_id), .spd_data(spd_data),
      .spd_sat(spd_sat), .overrun(overrun)
   );

   wheel_speed_scheduler #(.N_WHEELS(4), .WINDOW_CLKS(WIN), .CNT_W(4), .ID_W(2)) dut4 (
      .CLK(clk), .RST(rst), .enable(en4), .enc_a(enc_a), .window_strb(strb4),
      .spd_valid(valid4), .spd_ready(1'b1), .spd_id(id4), .spd_data(data4),
      .spd_sat(sat4), .overrun(ovr4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mk(input int id, input int data, input bit sat);
      return {4'd0, 1'b1, sat, 2'(id), 8'(data)};
   endfunction

   // handshake monitor: scoreboard pop on accept, stability check while stalled
   always @(negedge clk) begin
      logic [15:0] cur, cur4, e;
      cur  = {4'd0, spd_valid, spd_sat, spd_id, spd_data};
      cur4 = {4'd0, valid4, sat4, id4, 4'd0, data4};
      if (rst) begin
         stall = 1'b0;
      end else begin
         if (stall) chk("hold", cur, stall_v);
         if (spd_valid && spd_ready) begin
            if (q.size() == 0) chk("unexp_beat", cur, 16'd0);
            else begin
               e = q.pop_front();
               chk("beat", cur, e);
            end
            beat_cyc.push_back(cyc);
         end
         if (valid4) begin
            if (q4.size() == 0) chk("unexp_beat4", cur4, 16'd0);
            else begin
               e = q4.pop_front();
               chk("beat4", cur4, e);
            end
         end
         stall   = spd_valid && !spd_ready;
         stall_v = cur;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_strb"}, window_strb, 0);
      chk({tag, "_valid"}, spd_valid, 0);
      chk({tag, "_id"}, spd_id, 0);
      chk({tag, "_data"}, spd_data, 0);
      chk({tag, "_sat"}, spd_sat, 0);
      chk({tag, "_ovr"}, overrun, 0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1; enable = 1'b0; en4 = 1'b0; spd_ready = 1'b0; enc_a = '0;
      repeat (2) tick();
      chk_zero(tag);
      q.delete(); q4.delete(); beat_cyc.delete();
      rst = 1'b0;
   endtask

   task automatic run_pulses(input int n0, input int n1, input int n2, input int n3,
                             input int per, input int ncyc);
      int n[4];
      n = '{n0, n1, n2, n3};
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < 4; i++)
            enc_a[i] = ((c % per) < (per / 2)) && ((c / per) < n[i]);
         tick();
      end
      enc_a = '0;
   endtask

   task automatic wait_strb(output int t);
      bit found = 1'b0;
      t = 0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk);
         if (window_strb) begin
            found = 1'b1;
            t = cyc;
         end
      end
      chk("strb_seen", found, 1);
   endtask

   task automatic drain(input string tag, input int bound, input bit toggle);
      logic [3:0] pat = 4'b1001;
      int k = 0;
      while ((q.size() > 0 || q4.size() > 0) && k < bound) begin
         if (toggle) spd_ready = pat[k % 4];
         tick();
         k++;
      end
      chk({tag, "_drained"}, q.size() + q4.size(), 0);
      tick();
      chk({tag, "_idle"}, spd_valid, 0);
   endtask

   initial begin
      int t, e0, nstrb, nval;

      // A: nominal counts, ready held high, 4 back-to-back beats
      do_reset("rstA");
      for (int i = 0; i < 4; i++) q.push_back(mk(i, 5 * (i + 1), 0));
      spd_ready = 1'b1; enable = 1'b1; e0 = cyc;
      run_pulses(5, 10, 15, 20, 4, 80);
      wait_strb(t);
      chk("A_strb_cyc", t - e0, WIN);
      tick(); enable = 1'b0;
      drain("A", 20, 0);
      chk("A_nbeats", beat_cyc.size(), 4);
      if (beat_cyc.size() == 4) chk("A_b2b", beat_cyc[3] - beat_cyc[0], 3);

      // B: ready toggling 1-0-0-1 during the send
      do_reset("rstB");
      for (int i = 0; i < 4; i++) q.push_back(mk(i, i + 1, 0));
      enable = 1'b1;
      run_pulses(1, 2, 3, 4, 4, 20);
      wait_strb(t);
      tick(); enable = 1'b0;
      drain("B", 40, 1);

      // C: wheel0 every 2 CLK for two windows; 4-bit instance saturates at 15
      do_reset("rstC");
      for (int i = 0; i < 4; i++) q.push_back(mk(i, (i == 0) ? 49 : 0, 0));
      for (int i = 0; i < 4; i++) q.push_back(mk(i, (i == 0) ? 50 : 0, 0));
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 4; i++) q4.push_back(mk(i, (i == 0) ? 15 : 0, i == 0));
      spd_ready = 1'b1; enable = 1'b1; en4 = 1'b1;
      run_pulses(1000, 0, 0, 0, 2, 198);
      wait_strb(t);
      tick(); enable = 1'b0; en4 = 1'b0;
      drain("C", 20, 0);

      // D: edge landing one cycle before / on the end-event cycle
      do_reset("rstD");
      spd_ready = 1'b1;
      for (int i = 0; i < 4; i++) q.push_back(mk(i, (i == 0) ? 1 : 0, 0));
      for (int i = 0; i < 4; i++) q.push_back(mk(i, (i == 1) ? 1 : 0, 0));
      enable = 1'b1;
      repeat (97) tick();
      enc_a = 4'b0001; tick();
      enc_a = 4'b0010; tick();
      enc_a = 4'b0000;
      wait_strb(t);
      wait_strb(t);
      tick(); enable = 1'b0;
      drain("D", 20, 0);

      // E: ready held low across a second window -> overrun, first snapshot intact
      do_reset("rstE");
      for (int i = 0; i < 4; i++) q.push_back(mk(i, (i == 0) ? 3 : (i == 2) ? 4 : 1, 0));
      enable = 1'b1;
      run_pulses(3, 1, 4, 1, 4, 20);
      wait_strb(t);
      chk("E_ovr_before", overrun, 0);
      wait_strb(t);
      tick(); enable = 1'b0;
      chk("E_ovr_set", overrun, 1);
      repeat (10) tick();
      spd_ready = 1'b1;
      drain("E", 20, 0);
      chk("E_ovr_sticky", overrun, 1);

      // F: enable dropped mid-window, then a fresh window
      do_reset("rstF");
      spd_ready = 1'b1; enable = 1'b1;
      run_pulses(0, 0, 5, 0, 4, 20);
      repeat (30) tick();
      enable = 1'b0;
      nstrb = 0; nval = 0;
      repeat (150) begin
         @(negedge clk);
         if (window_strb) nstrb++;
         if (spd_valid) nval++;
      end
      chk("F_no_strb", nstrb, 0);
      chk("F_no_valid", nval, 0);
      tick();
      for (int i = 0; i < 4; i++) q.push_back(mk(i, 0, 0));
      enable = 1'b1; e0 = cyc;
      wait_strb(t);
      chk("F_strb_cyc", t - e0, WIN);
      tick(); enable = 1'b0;
      drain("F", 20, 0);

      // G: reset in the middle of a stalled send
      do_reset("rstG");
      enable = 1'b1;
      run_pulses(6, 0, 0, 0, 4, 24);
      wait_strb(t);
      tick(); enable = 1'b0;
      tick(); tick();
      chk("G_valid_pre", spd_valid, 1);
      chk("G_data_pre", spd_data, 6);
      rst = 1'b1;
      tick();
      chk_zero("G_rst");
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
